spi_master_ctrl: RTL

SPI master controller that sequences single-frame transfers to the SPI execution unit (mode 0: SCLK idles low, slave samples on rising edge, slave updates MISO on falling edge). A host issues a start pulse with a BITS-wide word. The block generates CS, a divided SCLK and MOSI (MSB first), samples MISO and returns the received word with a done pulse. It is the only driver of the execution unit's SPI pins in the system.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_clk_gen.sv | 44 ++++
 rtl/spi_master_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_pkg                                                                  |
// | Shared FSM state encoding and default geometry for the SPI master.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package spi_pkg;

  localparam int unsigned c_BITS_DEFAULT    = 5;
  localparam int unsigned c_CLK_DIV_DEFAULT = 2;
  localparam int unsigned c_CS_GAP_DEFAULT  = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/spi_clk_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_clk_gen                                                              |
// | Phase counter: one-cycle tick every CLK_DIV enabled cycles.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = c_CLK_DIV_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] c_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = (cnt_q == c_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tick = i_en && (cnt_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_master_ctrl                                                          |
// | Mode-0 SPI master: one BITS-wide frame per start, MSB first.             |
// | Option macro: SPI_MASTER_CTRL_BURST_EN (back-to-back frames, CS held).   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned BITS    = c_BITS_DEFAULT,
  parameter int unsigned CLK_DIV = c_CLK_DIV_DEFAULT,
  parameter int unsigned CS_GAP  = c_CS_GAP_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [BITS-1:0] i_data,
  output logic            o_busy,
  output logic            o_done,
  output logic [BITS-1:0] o_data,
  output logic            o_cs,
  output logic            o_sclk,
  output logic            o_mosi,
  input  logic            i_miso
);

  localparam int unsigned BW = $clog2(BITS + 1);
  localparam int unsigned GW = $clog2(CS_GAP + 2);
  localparam int          c_GAP_LAST_I = (CS_GAP > 0) ? int'(CS_GAP) - 1 : 0;
  localparam logic [BW-1:0] c_BIT_LAST = BW'(BITS - 1);
  localparam logic [GW-1:0] c_GAP_LAST = GW'(c_GAP_LAST_I);

`ifdef SPI_MASTER_CTRL_BURST_EN
  localparam bit c_BURST = 1'b1;
`else
  localparam bit c_BURST = 1'b0;
`endif

  state_e          state_q, state_d;
  logic [BITS-1:0] tx_q, tx_d;
  logic [BITS-1:0] rx_q, rx_d;
  logic [BITS-1:0] data_q, data_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            cs_q, cs_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            w_accept;
  logic            w_tick;
  logic            w_clk_en;
  logic [BITS-1:0] w_tx_shift;

  // A burst restart is only possible in the done cycle itself.
  assign w_accept   = i_start && ((state_q == ST_IDLE) ||
                                  (c_BURST && (state_q == ST_GAP) && done_q));
  assign w_clk_en   = (state_q == ST_SETUP) || (state_q == ST_HIGH) || (state_q == ST_LOW);
  assign w_tx_shift = tx_q << 1;

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_accept),
    .i_en   (w_clk_en),
    .o_tick (w_tick)
  );

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    data_d  = data_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;

    if (w_accept) begin
      state_d = ST_SETUP;
      tx_d    = i_data;
      rx_d    = '0;
      bit_d   = '0;
      cs_d    = 1'b0;
      sclk_d  = 1'b0;
      mosi_d  = i_data[BITS-1];
    end else begin
      case (state_q)
        ST_IDLE: begin
          cs_d = 1'b1;
        end
        ST_SETUP: begin
          if (w_tick) begin
            state_d = ST_HIGH;
            sclk_d  = 1'b1;
            rx_d    = BITS'({rx_q, i_miso});
          end
        end
        ST_HIGH: begin
          if (w_tick) begin
            state_d = ST_LOW;
            sclk_d  = 1'b0;
            tx_d    = w_tx_shift;
            mosi_d  = w_tx_shift[BITS-1];
          end
        end
        ST_LOW: begin
          if (w_tick) begin
            if (bit_q == c_BIT_LAST) begin
              state_d = (CS_GAP == 0) ? ST_IDLE : ST_GAP;
              // A held start keeps CS low so a burst restart is seamless.
              cs_d    = c_BURST ? ~i_start : 1'b1;
              mosi_d  = 1'b0;
              data_d  = rx_q;
              done_d  = 1'b1;
              gap_d   = '0;
            end else begin
              state_d = ST_HIGH;
              sclk_d  = 1'b1;
              bit_d   = bit_q + 1'b1;
              rx_d    = BITS'({rx_q, i_miso});
            end
          end
        end
        ST_GAP: begin
          cs_d = 1'b1;
          if (gap_q == c_GAP_LAST) begin
            state_d = ST_IDLE;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cs_d    = 1'b1;
          sclk_d  = 1'b0;
          mosi_d  = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      data_q  <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_data = data_q;
  assign o_cs   = cs_q;
  assign o_sclk = sclk_q;
  assign o_mosi = mosi_q;

endmodule
`default_nettype wire
